// File: rtl/pc_sequencer.sv
// Program counter register with redirect priority mux and a small circular
// return-address stack that overwrites its oldest entry when pushed while full.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] PCp1,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        call,
  input  logic        ret,
  input  logic [31:0] jump_target,
  output logic [31:0] PCOut,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_ovf,
  output logic        ras_unf
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   pc_q, pc_next;
  logic [31:0]   ras [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_next;
  logic [CW-1:0] count, count_next;
  logic          ovf_next, unf_next;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  assign PCOut     = pc_q;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));

  always_comb begin
    pc_next    = PCp1;
    ptr_next   = ptr;
    count_next = count;
    ovf_next   = ras_ovf;
    unf_next   = ras_unf;
    wr_en      = 1'b0;
    wr_idx     = ptr + PW'(1);
    if (stall) begin
      pc_next = pc_q;
    end else if (call && ret && !ras_empty) begin
      // swap: return to top entry and replace it with this call's return address
      pc_next = ras[ptr];
      wr_en   = 1'b1;
      wr_idx  = ptr;
    end else if (ret && !call) begin
      if (!ras_empty) begin
        pc_next    = ras[ptr];
        ptr_next   = ptr - PW'(1);
        count_next = count - CW'(1);
      end else begin
        unf_next = 1'b1;
      end
    end else if (call) begin
      pc_next  = jump_target;
      wr_en    = 1'b1;
      ptr_next = ptr + PW'(1);
      if (ras_full) ovf_next = 1'b1;
      else          count_next = count + CW'(1);
    end else if (jump) begin
      pc_next = jump_target;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc_q    <= RESET_PC;
      ptr     <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      pc_q    <= pc_next;
      ptr     <= ptr_next;
      count   <= count_next;
      ras_ovf <= ovf_next;
      ras_unf <= unf_next;
      if (wr_en) ras[wr_idx] <= PCp1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential, calls/returns,
// RAS overflow/underflow, stall, priority, swap, wrap and mid-run reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcp1;
  logic        stall, branch_taken, jump, call, ret;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_out;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // the bench plays the PC adder
  assign pcp1 = pc_out + 32'd1;

  pc_sequencer #(.RESET_PC(32'h100), .RAS_DEPTH(4)) dut (
    .CLK(clk), .RSTn(rst_n), .PCp1(pcp1), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
    .PCOut(pc_out), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    branch_target = '0;
    jump_target   = '0;
    #12;
    chk("reset_pc", pc_out, 32'h100);
    chk("reset_empty", {31'b0, ras_empty}, 1);
    chk("reset_full", {31'b0, ras_full}, 0);
    chk("reset_ovf", {31'b0, ras_ovf}, 0);
    chk("reset_unf", {31'b0, ras_unf}, 0);
    rst_n = 1'b1;

    step(); chk("seq1", pc_out, 32'h101);
    step(); chk("seq2", pc_out, 32'h102);
    step(); chk("seq3", pc_out, 32'h103);

    jump = 1; jump_target = 32'h10;
    step(); chk("jump_0x10", pc_out, 32'h10);
    idle();

    call = 1; jump_target = 32'h40;
    step(); chk("call_pc", pc_out, 32'h40);
    chk("call_empty", {31'b0, ras_empty}, 0);
    idle();
    step(); chk("sub1", pc_out, 32'h41);
    step(); chk("sub2", pc_out, 32'h42);
    step(); chk("sub3", pc_out, 32'h43);
    ret = 1;
    step(); chk("ret_pc", pc_out, 32'h11);
    chk("ret_empty", {31'b0, ras_empty}, 1);
    idle();

    // nested calls: pushes 0x12, 0x201, 0x301, 0x401, then 0x501 over 0x12
    call = 1;
    jump_target = 32'h200; step(); chk("n_call1", pc_out, 32'h200);
    jump_target = 32'h300; step(); chk("n_call2", pc_out, 32'h300);
    jump_target = 32'h400; step(); chk("n_call3", pc_out, 32'h400);
    chk("n_full3", {31'b0, ras_full}, 0);
    jump_target = 32'h500; step(); chk("n_call4", pc_out, 32'h500);
    chk("n_full4", {31'b0, ras_full}, 1);
    chk("n_ovf4", {31'b0, ras_ovf}, 0);
    jump_target = 32'h600; step(); chk("n_call5", pc_out, 32'h600);
    chk("n_ovf5", {31'b0, ras_ovf}, 1);
    chk("n_full5", {31'b0, ras_full}, 1);
    idle();
    ret = 1;
    step(); chk("n_ret1", pc_out, 32'h501);
    step(); chk("n_ret2", pc_out, 32'h401);
    step(); chk("n_ret3", pc_out, 32'h301);
    chk("n_unf3", {31'b0, ras_unf}, 0);
    step(); chk("n_ret4", pc_out, 32'h201);
    chk("n_empty4", {31'b0, ras_empty}, 1);
    step(); chk("n_ret5", pc_out, 32'h202);
    chk("n_unf5", {31'b0, ras_unf}, 1);
    idle();

    stall = 1; branch_taken = 1; branch_target = 32'h200;
    call = 1; jump_target = 32'h700;
    step(); chk("stall_pc", pc_out, 32'h202);
    chk("stall_empty", {31'b0, ras_empty}, 1);
    stall = 0; call = 0;
    step(); chk("post_stall_branch", pc_out, 32'h200);
    idle();

    branch_taken = 1; branch_target = 32'h90;
    jump = 1; call = 1; jump_target = 32'h80;
    step(); chk("prio_pc", pc_out, 32'h80);
    chk("prio_empty", {31'b0, ras_empty}, 0);
    chk("prio_full", {31'b0, ras_full}, 0);
    idle();
    call = 1; ret = 1; jump_target = 32'h999;
    step(); chk("swap_pc", pc_out, 32'h201);
    chk("swap_empty", {31'b0, ras_empty}, 0);
    idle();
    ret = 1;
    step(); chk("swap_top", pc_out, 32'h81);
    chk("swap_count", {31'b0, ras_empty}, 1);
    chk("ovf_sticky", {31'b0, ras_ovf}, 1);
    chk("unf_sticky", {31'b0, ras_unf}, 1);
    idle();

    jump = 1; jump_target = 32'hFFFF_FFFF;
    step(); chk("pc_max", pc_out, 32'hFFFF_FFFF);
    idle();
    step(); chk("wrap", pc_out, 32'h0);
    call = 1; jump_target = 32'h50;
    step(); chk("pre_rst_call", pc_out, 32'h50);
    chk("pre_rst_empty", {31'b0, ras_empty}, 0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc_out, 32'h100);
    chk("async_rst_empty", {31'b0, ras_empty}, 1);
    chk("async_rst_ovf", {31'b0, ras_ovf}, 0);
    chk("async_rst_unf", {31'b0, ras_unf}, 0);
    #1 rst_n = 1'b1;
    step(); chk("after_rst_seq", pc_out, 32'h101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
